// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative multiply/divide unit with architectural HI/LO registers.
// Multiply uses shift-add and divide uses restoring division, one bit per cycle.
// Both work on operand magnitudes; sign correction is applied in the DONE state.
module ex_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             flush,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_r;
  logic [CW-1:0]    cnt_r;
  logic             is_div_r;
  logic             neg_q_r;     // negate product / quotient
  logic             neg_rem_r;   // remainder takes dividend sign
  logic [WIDTH-1:0] a_raw_r;     // original dividend, returned on divide-by-zero
  logic [WIDTH-1:0] opnd_r;      // multiplicand or divisor magnitude
  logic [WIDTH-1:0] work_hi_r;   // product high half / partial remainder
  logic [WIDTH-1:0] work_lo_r;   // multiplier bits / dividend-quotient bits

  logic             accept_s;
  logic             sign_a_s;
  logic             sign_b_s;
  logic [WIDTH-1:0] a_mag_s;
  logic [WIDTH-1:0] b_mag_s;
  logic [WIDTH:0]   mul_sum_s;
  logic [WIDTH:0]   div_shift_s;
  logic [WIDTH:0]   div_diff_s;
  logic [WIDTH-1:0] step_hi_s;
  logic [WIDTH-1:0] step_lo_s;
  logic [2*WIDTH-1:0] prod_neg_s;
  logic [WIDTH-1:0] res_hi_s;
  logic [WIDTH-1:0] res_lo_s;

  // Two's-complement magnitude when neg is set, identity otherwise.
  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v, input logic neg);
    logic [WIDTH-1:0] r;
    if (neg) begin
      r = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      r = v;
    end
    return r;
  endfunction

  // Decode a request and compute operand magnitudes and signs.
  always_comb begin
    accept_s = in_valid & in_ready & ~flush & (in_op[2:1] != 2'b11);
    sign_a_s = ~in_op[2] & ~in_op[0] & in_a[WIDTH-1];
    sign_b_s = ~in_op[2] & ~in_op[0] & in_b[WIDTH-1];
    a_mag_s  = abs_val(in_a, sign_a_s);
    b_mag_s  = abs_val(in_b, sign_b_s);
  end

  // One iteration of shift-add multiply or restoring divide.
  always_comb begin
    mul_sum_s   = {1'b0, work_hi_r} + (work_lo_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
    div_shift_s = {work_hi_r, work_lo_r[WIDTH-1]};
    div_diff_s  = div_shift_s - {1'b0, opnd_r};
    if (is_div_r) begin
      if (!div_diff_s[WIDTH]) begin
        step_hi_s = div_diff_s[WIDTH-1:0];
        step_lo_s = {work_lo_r[WIDTH-2:0], 1'b1};
      end else begin
        step_hi_s = div_shift_s[WIDTH-1:0];
        step_lo_s = {work_lo_r[WIDTH-2:0], 1'b0};
      end
    end else begin
      step_hi_s = mul_sum_s[WIDTH:1];
      step_lo_s = {mul_sum_s[0], work_lo_r[WIDTH-1:1]};
    end
  end

  // Sign-corrected final result presented while in DONE.
  always_comb begin
    prod_neg_s = -{work_hi_r, work_lo_r};
    if (is_div_r) begin
      if (opnd_r == {WIDTH{1'b0}}) begin
        res_hi_s = a_raw_r;
        res_lo_s = {WIDTH{1'b1}};
      end else begin
        res_hi_s = neg_rem_r ? -work_hi_r : work_hi_r;
        res_lo_s = neg_q_r ? -work_lo_r : work_lo_r;
      end
    end else begin
      if (neg_q_r) begin
        res_hi_s = prod_neg_s[2*WIDTH-1:WIDTH];
        res_lo_s = prod_neg_s[WIDTH-1:0];
      end else begin
        res_hi_s = work_hi_r;
        res_lo_s = work_lo_r;
      end
    end
  end

  // Control FSM, iteration datapath and HI/LO registers with registered status outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r   <= S_IDLE;
      cnt_r     <= {CW{1'b0}};
      is_div_r  <= 1'b0;
      neg_q_r   <= 1'b0;
      neg_rem_r <= 1'b0;
      a_raw_r   <= {WIDTH{1'b0}};
      opnd_r    <= {WIDTH{1'b0}};
      work_hi_r <= {WIDTH{1'b0}};
      work_lo_r <= {WIDTH{1'b0}};
      hi        <= {WIDTH{1'b0}};
      lo        <= {WIDTH{1'b0}};
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          done <= 1'b0;
          if (accept_s) begin
            case (in_op)
              OP_MTHI: hi <= in_a;
              OP_MTLO: lo <= in_a;
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                is_div_r  <= in_op[1];
                neg_q_r   <= sign_a_s ^ sign_b_s;
                neg_rem_r <= sign_a_s;
                a_raw_r   <= in_a;
                cnt_r     <= {CW{1'b0}};
                work_hi_r <= {WIDTH{1'b0}};
                if (in_op[1]) begin
                  opnd_r    <= b_mag_s;
                  work_lo_r <= a_mag_s;
                end else begin
                  opnd_r    <= a_mag_s;
                  work_lo_r <= b_mag_s;
                end
                state_r  <= S_RUN;
                in_ready <= 1'b0;
                busy     <= 1'b1;
              end
              default: begin
                state_r <= S_IDLE;
              end
            endcase
          end
        end
        S_RUN: begin
          if (flush) begin
            state_r  <= S_IDLE;
            in_ready <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
          end else begin
            work_hi_r <= step_hi_s;
            work_lo_r <= step_lo_s;
            cnt_r     <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
            if (cnt_r == CW'(WIDTH - 1)) begin
              state_r <= S_DONE;
              done    <= 1'b1;
            end
          end
        end
        S_DONE: begin
          state_r  <= S_IDLE;
          in_ready <= 1'b1;
          busy     <= 1'b0;
          done     <= 1'b0;
          if (!flush) begin
            hi <= res_hi_s;
            lo <= res_lo_s;
          end
        end
        default: begin
          state_r  <= S_IDLE;
          in_ready <= 1'b1;
          busy     <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed self-checking bench for ex_muldiv (WIDTH = 32).
module tb_ex_muldiv;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         resetn;
  logic         in_valid;
  logic [2:0]   in_op;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         flush;
  logic         in_ready;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ex_muldiv #(.WIDTH(W)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .in_valid (in_valid),
    .in_op    (in_op),
    .in_a     (in_a),
    .in_b     (in_b),
    .flush    (flush),
    .in_ready (in_ready),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ehi;
    logic [31:0] elo;
    string       name;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one multi-cycle op from IDLE and check latency, pulse width and result.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo, input string name);
    int n;
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
    tick();
    in_valid = 1'b0;
    check({name, "_busy"}, {63'd0, busy}, 64'd1);
    n = 1;
    while (!done && n < 100) begin
      tick();
      n++;
    end
    check({name, "_latency"}, 64'(n), 64'(W + 1));
    tick();
    check({name, "_done_pulse"}, {63'd0, done}, 64'd0);
    check({name, "_ready"}, {63'd0, in_ready}, 64'd1);
    check({name, "_hi"}, {32'd0, hi}, {32'd0, ehi});
    check({name, "_lo"}, {32'd0, lo}, {32'd0, elo});
  endtask

  // Watch a number of cycles and return how many had done high.
  task automatic count_done(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      if (done) cnt++;
      tick();
    end
  endtask

  initial begin
    int n;
    vecs[0]  = '{3'b000, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, "mult_m3x5"};
    vecs[1]  = '{3'b001, 32'hFFFFFFFD, 32'h00000005, 32'h00000004, 32'hFFFFFFF1, "multu_fffdx5"};
    vecs[2]  = '{3'b011, 32'd100,      32'd7,        32'd2,        32'd14,       "divu_100_7"};
    vecs[3]  = '{3'b010, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, "div_m7_2"};
    vecs[4]  = '{3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "div_min_m1"};
    vecs[5]  = '{3'b011, 32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFF, "divu_by0"};
    vecs[6]  = '{3'b010, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, "div_m7_by0"};
    vecs[7]  = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu_max"};
    vecs[8]  = '{3'b010, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, "div_7_m2"};
    vecs[9]  = '{3'b000, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, "mult_min_min"};
    vecs[10] = '{3'b011, 32'hFFFFFFFF, 32'd16,       32'h0000000F, 32'h0FFFFFFF, "divu_max_16"};
    vecs[11] = '{3'b000, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, "mult_7_m1"};

    resetn = 1'b0; in_valid = 1'b0; in_op = 3'b000; in_a = 32'd0; in_b = 32'd0; flush = 1'b0;
    #12;
    check("rst_ready", {63'd0, in_ready}, 64'd1);
    check("rst_busy",  {63'd0, busy},     64'd0);
    check("rst_done",  {63'd0, done},     64'd0);
    check("rst_hi",    {32'd0, hi},       64'd0);
    check("rst_lo",    {32'd0, lo},       64'd0);
    tick();
    resetn = 1'b1;
    tick();

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ehi, vecs[i].elo, vecs[i].name);
    end

    // MTHI then MTLO back-to-back; busy must never rise.
    n = 0;
    in_valid = 1'b1; in_op = 3'b100; in_a = 32'h55;
    tick();
    if (busy) n++;
    in_op = 3'b101; in_a = 32'h66;
    tick();
    if (busy) n++;
    in_valid = 1'b0;
    tick();
    if (busy) n++;
    check("mt_busy_cycles", 64'(n), 64'd0);
    check("mthi_hi", {32'd0, hi}, 64'h55);
    check("mtlo_lo", {32'd0, lo}, 64'h66);

    // Requests arriving during RUN are dropped.
    in_valid = 1'b1; in_op = 3'b001; in_a = 32'd3; in_b = 32'd4;
    tick();
    in_op = 3'b100; in_a = 32'hDEAD;
    for (int i = 0; i < 5; i++) tick();
    in_valid = 1'b0;
    n = 0;
    while (!done && n < 100) begin
      tick();
      n++;
    end
    check("ignore_done_seen", {63'd0, done}, 64'd1);
    tick();
    check("ignore_hi", {32'd0, hi}, 64'd0);
    check("ignore_lo", {32'd0, lo}, 64'd12);
    tick();
    check("ignore_no_restart", {63'd0, busy}, 64'd0);

    // Flush during RUN cycle 10 of a MULT leaves HI/LO untouched.
    in_valid = 1'b1; in_op = 3'b100; in_a = 32'hA;
    tick();
    in_op = 3'b101; in_a = 32'hB;
    tick();
    in_op = 3'b000; in_a = 32'd3; in_b = 32'd5;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    check("flush_busy_c10", {63'd0, busy}, 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_ready", {63'd0, in_ready}, 64'd1);
    check("flush_busy",  {63'd0, busy},     64'd0);
    count_done(40, n);
    check("flush_no_done", 64'(n), 64'd0);
    check("flush_hi", {32'd0, hi}, 64'hA);
    check("flush_lo", {32'd0, lo}, 64'hB);

    // Flush in IDLE blocks the accept.
    in_valid = 1'b1; flush = 1'b1; in_op = 3'b100; in_a = 32'h77;
    tick();
    in_op = 3'b000;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    check("idle_flush_hi",   {32'd0, hi}, 64'hA);
    check("idle_flush_busy", {63'd0, busy}, 64'd0);

    // Reset asserted mid-DIV clears everything immediately.
    in_valid = 1'b1; in_op = 3'b011; in_a = 32'd100; in_b = 32'd7;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    resetn = 1'b0;
    #1;
    check("arst_ready", {63'd0, in_ready}, 64'd1);
    check("arst_busy",  {63'd0, busy},     64'd0);
    check("arst_hi",    {32'd0, hi},       64'd0);
    check("arst_lo",    {32'd0, lo},       64'd0);
    tick();
    tick();
    resetn = 1'b1;
    in_valid = 1'b1; in_op = 3'b100; in_a = 32'h99;
    tick();
    in_valid = 1'b0;
    check("arst_first_accept", {32'd0, hi}, 64'h99);
    count_done(40, n);
    check("arst_no_done", 64'(n), 64'd0);
    check("arst_lo_kept", {32'd0, lo}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
